// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter sharing one 512-bit line-read port between cache fill requesters.
// One read in flight at a time; the returned line is registered and pulsed to the granted client only.
module line_fill_arbiter #(
  parameter int CLIENTS   = 2,
  parameter int LINE_BITS = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CLIENTS-1:0]      req_cyc,
  input  logic [64*CLIENTS-1:0]   req_addr,
  output logic [CLIENTS-1:0]      resp_cyc,
  output logic [LINE_BITS-1:0]    resp_data,
  output logic                    mem_reqcyc,
  output logic [63:0]             mem_addr,
  input  logic                    mem_respcyc,
  input  logic [LINE_BITS-1:0]    mem_data
);

  localparam int GW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        next_rr;
  logic                 pick_vld;
  logic [63:0]          pick_addr;
  logic [CLIENTS-1:0]   grant_onehot;

  // First requester at or after rr_ptr, wrapping modulo CLIENTS.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      for (int i = 0; i < CLIENTS; i++) begin
        if (!pick_vld && req_cyc[i] && (((int'(rr_ptr) + k) % CLIENTS) == i)) begin
          pick_vld = 1'b1;
          pick     = GW'(i);
        end
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (GW'(i) == pick) pick_addr = req_addr[64*i +: 64];
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      grant_onehot[i] = (GW'(i) == grant);
    end
  end

  assign next_rr = (grant == GW'(CLIENTS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      resp_cyc   <= '0;
      mem_reqcyc <= 1'b0;
      mem_addr   <= '0;
      resp_data  <= '0;
    end else begin
      resp_cyc   <= '0;
      mem_reqcyc <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant      <= pick;
            mem_addr   <= pick_addr & ~64'd63;
            mem_reqcyc <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_respcyc) begin
            resp_data <= mem_data;
            resp_cyc  <= grant_onehot;
            state     <= RESP;
          end
        end
        RESP: begin
          // Priority rotates only once the line has been delivered.
          rr_ptr <= next_rr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
